// File: rtl/rom_play_pkg.sv
// rom_play_pkg: shared types and constants for the ROM playback sequencer
package rom_play_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;
    typedef enum logic [1:0] {PAUSE = 2'd0, RUN = 2'd1, FETCH = 2'd2} state_t;
endpackage

// File: rtl/key_filter.sv
// key_filter: synchronises and debounces an active-low key into a one-cycle press pulse
module key_filter #(
    parameter logic [19:0] DEB_MAX = 20'd999_999
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_in,
    output logic key_flag
);
    logic [1:0]  key_sync;
    logic [19:0] cnt;
    logic        held;
    logic        low;
    logic        at_max;
    assign low    = !key_sync[1];
    assign at_max = low && cnt == DEB_MAX;
    // held remembers that this press already fired, so a long press pulses once
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_sync <= 2'b11;
            cnt      <= '0;
            held     <= 1'b0;
            key_flag <= 1'b0;
        end else begin
            key_sync <= {key_sync[0], key_in};
            cnt      <= !low ? 20'd0 : (cnt == DEB_MAX ? cnt : cnt + 20'd1);
            held     <= at_max;
            key_flag <= at_max && !held;
        end
    end
endmodule

// File: rtl/rom_play_ctrl.sv
// rom_play_ctrl: auto-run / single-step ROM address sequencer with latency-aligned data latch
module rom_play_ctrl
    import rom_play_pkg::*;
#(
    parameter logic [23:0] CNT_MAX = 24'd9_999_999,
    parameter logic [19:0] DEB_MAX = 20'd999_999,
    parameter int          ROM_LAT = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              key1,
    input  logic              key2,
    input  logic [DATA_W-1:0] rom_q,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              run,
    output logic              dir
);
    localparam logic [2:0] LAT_LAST = 3'(ROM_LAT - 1);
    state_t      state, state_nxt;
    logic        k1_flag, k2_flag, pend1, pend2;
    logic [23:0] tick;
    logic [2:0]  lat_cnt;
    logic        busy, ev1, ev2, tick_done, fetch_done, step;
    key_filter #(.DEB_MAX(DEB_MAX)) u_key1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_in(key1), .key_flag(k1_flag)
    );
    key_filter #(.DEB_MAX(DEB_MAX)) u_key2 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_in(key2), .key_flag(k2_flag)
    );
    // key1 outranks key2; pending flags replay events that arrived during FETCH
    always_comb begin
        busy       = state == FETCH;
        ev1        = !busy && (k1_flag || pend1);
        ev2        = !busy && (k2_flag || pend2) && !ev1;
        tick_done  = state == RUN && tick == CNT_MAX;
        fetch_done = busy && lat_cnt == LAT_LAST;
        step       = (state == PAUSE && ev2) || (tick_done && !ev1);
        state_nxt  = busy ? (fetch_done ? (run ? RUN : PAUSE) : FETCH)
                   : ev1 ? (run ? PAUSE : RUN)
                   : step ? FETCH : state;
    end
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= FETCH;
        else            state <= state_nxt;
    end
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            addr       <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            run        <= 1'b0;
            dir        <= DIR_UP;
            tick       <= '0;
            lat_cnt    <= '0;
            pend1      <= 1'b0;
            pend2      <= 1'b0;
        end else begin
            pend1      <= busy && (pend1 || k1_flag);
            pend2      <= busy && (pend2 || k2_flag);
            lat_cnt    <= (busy && !fetch_done) ? lat_cnt + 3'd1 : 3'd0;
            data_valid <= fetch_done;
            if (fetch_done) data_out <= rom_q;
            if (step) addr <= (dir == DIR_UP) ? addr + 8'd1 : addr - 8'd1;
            if (ev1) run <= !run;
            if (state == RUN && ev2) dir <= (dir == DIR_UP) ? DIR_DN : DIR_UP;
            if (state == PAUSE && ev1) tick <= '0;
            else if (state == RUN && !ev1) tick <= tick_done ? 24'd0 : tick + 24'd1;
        end
    end
endmodule
